// File: rtl/expr_pkg.sv
// expr_pkg: ASCII constants, FSM encoding and character/LFSR helpers shared by generator and recognizer
package expr_pkg;
    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_NINE = 8'h39;
    localparam logic [7:0] CH_MUL  = 8'h2A;
    localparam logic [7:0] CH_ADD  = 8'h2B;
    localparam logic [7:0] CH_BAD  = 8'h23;

    typedef enum logic [1:0] {IDLE, DIGIT, OP} state_t;

    function automatic logic [7:0] digit_ch(input logic [7:0] l);
        return CH_ZERO + {4'h0, (l[3:0] >= 4'd10) ? l[3:0] - 4'd10 : l[3:0]};
    endfunction

    function automatic logic [7:0] op_ch(input logic [7:0] l);
        return l[4] ? CH_MUL : CH_ADD;
    endfunction

    // Fibonacci x^8+x^6+x^5+x^4+1, shifting left
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction
endpackage

// File: rtl/expr_lfsr8.sv
// expr_lfsr8: 8-bit LFSR with enable, seed load and all-zero lockup recovery
module expr_lfsr8
    import expr_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       en,
    input  logic       load,
    output logic [7:0] q,
    output logic [7:0] nxt
);
    logic [7:0] state_q, state_d;

    // next value a transfer would produce; zero reloads the seed
    always_comb begin
        nxt     = (state_q == 8'h00) ? SEED : lfsr_step(state_q);
        state_d = load ? SEED : (en || state_q == 8'h00) ? nxt : state_q;
    end

    // state register
    always_ff @(posedge clk) state_q <= state_d;

    assign q = state_q;
endmodule

// File: rtl/expr_stream_gen.sv
// expr_stream_gen: emits random digit(op digit)* expressions over valid/ready with expected recognizer output
module expr_stream_gen
    import expr_pkg::*;
#(
    parameter int         MAX_TERMS = 8,
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [3:0] terms,
    input  logic       bad,
    output logic [7:0] ch,
    output logic       valid,
    input  logic       ready,
    output logic       last,
    output logic       expect_out,
    output logic       busy
);
    state_t     state_q, state_d;
    logic [3:0] n_q, n_d, cnt_q, cnt_d, n_in, cnt_inc;
    logic       bad_q, bad_d, valid_q, valid_d, last_q, last_d, exp_q, exp_d, busy_q, busy_d;
    logic [7:0] ch_q, ch_d, lfsr, lfsr_nx;
    logic       xfer, fin_in, fin_op;

    expr_lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .en  (xfer),
        .load(clr),
        .q   (lfsr),
        .nxt (lfsr_nx)
    );

    // next-state and next-character selection; characters come from the LFSR value held while presented
    always_comb begin
        xfer    = valid_q && ready;
        n_in    = (terms == 4'd0) ? 4'd1 : (int'(terms) > MAX_TERMS) ? 4'(MAX_TERMS) : terms;
        cnt_inc = cnt_q + 4'd1;
        fin_in  = (n_in == 4'd1);
        fin_op  = (cnt_inc == n_q);
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        last_d  = last_q;
        exp_d   = exp_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = DIGIT;
                n_d     = n_in;
                bad_d   = bad;
                cnt_d   = 4'd1;
                ch_d    = (fin_in && bad) ? CH_BAD : digit_ch(lfsr);
                last_d  = fin_in;
                exp_d   = !(fin_in && bad);
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            DIGIT: if (xfer) begin
                state_d = (cnt_q == n_q) ? IDLE : OP;
                valid_d = (cnt_q != n_q);
                busy_d  = (cnt_q != n_q);
                ch_d    = op_ch(lfsr_nx);
                last_d  = 1'b0;
                exp_d   = 1'b0;
            end
            OP: if (xfer) begin
                state_d = DIGIT;
                cnt_d   = cnt_inc;
                ch_d    = (fin_op && bad_q) ? CH_BAD : digit_ch(lfsr_nx);
                last_d  = fin_op;
                exp_d   = !(fin_op && bad_q);
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, counters and registered outputs; clr overrides everything
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            ch_q    <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            exp_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
        end
    end

    assign ch         = ch_q;
    assign valid      = valid_q;
    assign last       = last_q;
    assign expect_out = exp_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_expr_stream_gen.sv
// tb_expr_stream_gen: directed scoreboard bench for expr_stream_gen
module tb_expr_stream_gen;
    logic       clk = 1'b0;
    logic       clr, start, bad, ready, valid, last, exp_o, busy;
    logic [3:0] terms;
    logic [7:0] ch, m, first_ch;
    logic [9:0] sb[$];
    int         total = 0, passed = 0;

    always #5 clk = ~clk;

    expr_stream_gen dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .terms     (terms),
        .bad       (bad),
        .ch        (ch),
        .valid     (valid),
        .ready     (ready),
        .last      (last),
        .expect_out(exp_o),
        .busy      (busy)
    );

    function automatic logic [7:0] step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] dig(input logic [7:0] s);
        logic [3:0] lo;
        lo = s[3:0];
        return 8'h30 + {4'h0, (lo >= 4'd10) ? lo - 4'd10 : lo};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // expected characters as {ch, last, expect}, advancing the model LFSR per transfer
    task automatic push_expr(input logic [3:0] t, input logic b);
        int  n;
        logic fin;
        n = (t == 0) ? 1 : (t > 8) ? 8 : int'(t);
        for (int i = 1; i <= n; i++) begin
            fin = (i == n);
            sb.push_back({(fin && b) ? 8'h23 : dig(m), fin, !(fin && b)});
            m = step(m);
            if (!fin) begin
                sb.push_back({m[4] ? 8'h2A : 8'h2B, 1'b0, 1'b0});
                m = step(m);
            end
        end
    endtask

    task automatic run(input logic [3:0] t, input logic b, input int stall_at, input int stall_len, input int start_at);
        int got = 0, cyc = 0, stl = stall_len, len;
        push_expr(t, b);
        len   = sb.size();
        start = 1'b1;
        terms = t;
        bad   = b;
        ready = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        first_ch = ch;
        check("first_valid", 32'(valid), 1);
        while (got < len && cyc < 100) begin
            cyc++;
            start = (got == start_at);
            ready = !(got == stall_at && stl > 0);
            if (!ready) begin
                stl--;
                check("stall_hold", 32'({ch, last, exp_o}), 32'(sb[0]));
            end else begin
                check("valid", 32'(valid), 1);
                check("busy", 32'(busy), 1);
                check("char", 32'({ch, last, exp_o}), 32'(sb.pop_front()));
                got++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("char_count", got, len);
        check("end_valid", 32'(valid), 0);
        check("end_busy", 32'(busy), 0);
        @(negedge clk);
        check("no_extra", 32'(valid), 0);
    endtask

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        terms = 4'd0;
        bad   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ch", 32'(ch), 32'h00);
        check("rst_last", 32'(last), 0);
        check("rst_expect", 32'(exp_o), 0);
        clr = 1'b0;
        m   = 8'hA5;
        run(4'd3, 1'b0, -1, 0, -1);
        check("seed_char", 32'(first_ch), 32'h35);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m   = 8'hA5;
        run(4'd2, 1'b0, 1, 3, -1);
        check("seed_char_stall", 32'(first_ch), 32'h35);
        run(4'd2, 1'b1, -1, 0, -1);
        run(4'd0, 1'b0, -1, 0, -1);
        run(4'd15, 1'b0, 4, 2, -1);
        run(4'd1, 1'b1, -1, 0, -1);
        run(4'd3, 1'b0, -1, 0, 1);
        run(4'd2, 1'b0, -1, 0, 2);
        start = 1'b1;
        terms = 4'd5;
        bad   = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_valid", 32'(valid), 0);
        check("clr_busy", 32'(busy), 0);
        check("clr_ch", 32'(ch), 32'h00);
        sb.delete();
        m = 8'hA5;
        run(4'd1, 1'b0, -1, 0, -1);
        check("seed_char_clr", 32'(first_ch), 32'h35);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
